id_ex_stage: RTL

//  ID->EX pipeline stage directly downstream of the decoder. It captures decoded controls
//  (opa_sel, opb_sel, alu_op, rd) with PC and register-file data, and resolves ALU operands A/B.

---
 rtl/id_ex_stage.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID->EX pipeline stage: resolves ALU operands A/B and registers them behind a valid/ready
// handshake with a one-entry skid buffer. Optional rs1 forwarding from EX/MEM under `FWD_EN.
//
// state | meaning
// EMPTY | no payload held, o_valid=0
// ONE   | main register holds the payload driving the outputs
// FULL  | main + skid both held, skid is the younger entry, o_ready=0
module id_ex_stage #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [XLEN-1:0]    i_pc,
  input  logic [4:0]         i_rs1_addr,
  input  logic [XLEN-1:0]    i_rs1_data,
  input  logic [XLEN-1:0]    i_rs2_data,
  input  logic [XLEN-1:0]    i_imm,
  input  logic [1:0]         i_opa_sel,
  input  logic               i_opb_sel,
  input  logic [ALUOP_W-1:0] i_alu_op,
  input  logic [4:0]         i_rd_addr,
  input  logic               i_rd_wren,
  input  logic               i_fwd_wren,
  input  logic [4:0]         i_fwd_rd,
  input  logic [XLEN-1:0]    i_fwd_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [XLEN-1:0]    o_operand_a,
  output logic [XLEN-1:0]    o_operand_b,
  output logic [ALUOP_W-1:0] o_alu_op,
  output logic [4:0]         o_rd_addr,
  output logic               o_rd_wren,
  output logic [XLEN-1:0]    o_pc
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [XLEN-1:0]    a;
    logic [XLEN-1:0]    b;
    logic [XLEN-1:0]    pc;
    logic [ALUOP_W-1:0] alu_op;
    logic [4:0]         rd;
    logic               wren;
  } payload_t;

  state_t   state, state_nxt;
  logic     ready_q;
  payload_t main_q, skid_q, in_pl;
  logic     fwd_hit;
  logic     accept, transfer;
  logic     load_main_in, load_main_skid, load_skid;

`ifdef FWD_EN
  assign fwd_hit = i_fwd_wren && (i_fwd_rd != 5'd0) && (i_fwd_rd == i_rs1_addr) &&
                   (i_opa_sel == 2'b00);
`else
  logic unused_fwd;
  assign unused_fwd = ^{i_fwd_wren, i_fwd_rd, i_fwd_data, i_rs1_addr};
  assign fwd_hit    = 1'b0;
`endif

  always_comb begin
    in_pl        = '0;
    in_pl.pc     = i_pc;
    in_pl.alu_op = i_alu_op;
    in_pl.rd     = i_rd_addr;
    in_pl.wren   = i_rd_wren;
    case (i_opa_sel)
      2'b00:   in_pl.a = fwd_hit ? i_fwd_data : i_rs1_data;
      2'b01:   in_pl.a = i_pc;
      default: in_pl.a = '0;
    endcase
    in_pl.b = i_opb_sel ? i_imm : i_rs2_data;
  end

  assign accept   = i_valid && ready_q;
  assign transfer = o_valid && i_ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_nxt    = ONE;
        load_main_in = 1'b1;
      end
      ONE: begin
        if (accept && transfer) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (transfer) begin
          state_nxt = EMPTY;
        end
      end
      FULL: if (transfer) begin
        state_nxt      = ONE;
        load_main_skid = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (i_flush) begin
      // Payload regs keep stale data; o_valid=0 and gated o_rd_wren make it harmless.
      state   <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != FULL);
      if (load_main_in)        main_q <= in_pl;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_pl;
      else if (load_main_skid) skid_q <= '0;
    end
  end

  assign o_ready     = ready_q;
  assign o_valid     = (state != EMPTY);
  assign o_operand_a = main_q.a;
  assign o_operand_b = main_q.b;
  assign o_alu_op    = main_q.alu_op;
  assign o_rd_addr   = main_q.rd;
  assign o_rd_wren   = main_q.wren && o_valid;
  assign o_pc        = main_q.pc;

endmodule
